ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
Sequences the single AHB master port of the multicycle core and shares it between two requesters: instruction fetch (IF) and load/store data (D). The block performs one single-beat NONSEQ transfer at a time and handles wait states, the two-cycle ERROR response and a wait-state timeout. It also prevents fetch starvation. It sits between the core's control FSM and the AHB interconnect (decoder/mux/slaves).

Parameters:
STARVE_LIMIT, 4, consecutive D grants allowed while if_req is pending before IF is forced to win (1..15)
TIMEOUT, 16, hready-low cycles tolerated in one transfer before abort (2..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  32  fetch address, word aligned
if_gnt  out  1  1-cycle pulse: fetch accepted
if_done  out  1  1-cycle pulse: fetch finished; if_rdata valid this cycle
if_err  out  1  qualifies if_done: fetch failed
if_rdata  out  32  fetched word
d_req  in  1  data request; held with payload until d_gnt
d_write  in  1  1 = store
d_size  in  3  0 = byte, 1 = half, 2 = word
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  1-cycle pulse: data request accepted
d_done  out  1  1-cycle pulse: data transfer finished
d_err  out  1  qualifies d_done
d_rdata  out  32  load data
htrans  out  2  00 = IDLE, 10 = NONSEQ only
haddr  out  32  AHB address
hwrite  out  1  AHB write
hsize  out  3  AHB size
hprot  out  4  fetch 4'b0010, data 4'b0011
hwdata  out  32  write data, driven in the data phase
hmaster  out  1  current owner: 0 = IF, 1 = D
hrdata  in  32  read data from the AHB mux
hready  in  1  transfer ready
hresp  in  1  1 = ERROR

Behaviour:
- Reset is asynchronous: all outputs, counters and state are cleared to 0; state = IDLE; htrans = 00.
- Reset asserted mid-transfer aborts the transfer silently. No done or err pulse is produced. Requesters re-issue after reset.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, ERR, REJ.
- IDLE: htrans = 00. When any request is pending, pick a winner.
  - D wins by default.
  - IF wins if only if_req is set, or if starve_cnt >= STARVE_LIMIT.
  - At that edge: pulse the winner's gnt; latch the winner's address, write, size, wdata and hprot; set hmaster; go to ADDR.
  - A D request with d_size > 2, or an address misaligned for its size, goes to REJ instead and does not touch the bus.
- ADDR: htrans = 10 with haddr/hwrite/hsize/hprot valid.
  - If hready = 1, go to DATA.
  - Otherwise hold all address-phase signals stable.
- DATA: htrans = 00; hwdata = latched wdata.
  - hready = 1 and hresp = 0: capture hrdata into the owner's rdata; pulse done; go to IDLE.
  - hready = 0 and hresp = 1: go to ERR.
- ERR: wait for hready = 1, then pulse done + err with rdata = 0, and go to IDLE.
- REJ: pulse d_done + d_err for one cycle, then go to IDLE.
- Zero-wait latency: request sampled at edge N gives gnt in cycle N+1 (address phase), data phase in N+2, and done in N+3. A new grant is possible from cycle N+4.
- Requests are ignored between gnt and done. The other requester simply waits.
- starve_cnt (4-bit saturating):
  - increments on each D grant while if_req = 1;
  - clears on an IF grant or whenever if_req = 0.
- wait_cnt:
  - clears on entry to ADDR;
  - increments each ADDR/DATA/ERR cycle with hready = 0.
  - At wait_cnt = TIMEOUT: pulse done + err, force htrans = 00, go to IDLE.
- Store hsize comes from d_size. Fetch hsize is always 3'b010.
- Byte lane placement and sign extension are done outside this block. d_rdata/if_rdata is the raw hrdata word.
- Simultaneous if_req and d_req in IDLE: exactly one gnt is issued per cycle.
- When done is pulsed, the other requester's pending request may be granted at the next IDLE edge.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0040, hready = 1 always, hrdata = 0x0051_3023 -> if_gnt in cycle 1 with htrans = 10 and haddr = 0x40; if_done in cycle 3 with if_rdata = 0x0051_3023 and if_err = 0.
- Store with 2 wait states: d_write = 1, d_size = 2, d_addr = 0x1000_0008, d_wdata = 0xDEAD_BEEF, hready low for 2 data-phase cycles -> hwdata = 0xDEAD_BEEF held throughout; d_done 2 cycles later than zero-wait; hprot = 0011.
- Contention and starvation: if_req and d_req held high continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, IF, repeating; hmaster follows the grants.
- Error response: hresp = 1 with hready = 0 for one data-phase cycle, then hresp = 1 with hready = 1 -> d_done = d_err = 1 and d_rdata = 0; FSM back in IDLE.
- Timeout and misalignment: hready stuck at 0 with TIMEOUT = 16 -> err pulse after 16 wait cycles and htrans = 00. d_size = 2 with d_addr = 0x1000_0002 -> d_gnt, then d_done + d_err, and htrans never leaves 00.
- Reset mid-transfer: reset driven low during the DATA state -> all outputs 0 immediately with no done pulse; after release, a new if_req completes normally.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Single-master AHB sequencer shared between instruction fetch and load/store.
// One NONSEQ single-beat transfer at a time, with wait states, ERROR response, timeout and anti-starvation.
module ahb_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    output logic        hmaster,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        ERR  = 3'd3,
        REJ  = 3'd4
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [3:0] STARVE_LIM   = 4'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_LIM  = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [3:0]  starve_cnt, starve_n;
    logic [7:0]  wait_cnt, wait_n;
    logic [31:0] wdata_lat, wdata_n;

    logic        if_gnt_n, if_done_n, if_err_n;
    logic        d_gnt_n, d_done_n, d_err_n;
    logic [31:0] if_rdata_n, d_rdata_n;
    logic [1:0]  htrans_n;
    logic [31:0] haddr_n, hwdata_n;
    logic        hwrite_n, hmaster_n;
    logic [2:0]  hsize_n;
    logic [3:0]  hprot_n;

    logic        pick_if, d_aligned, fin_ok, fin_err;
    logic [7:0]  wait_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            wdata_lat  <= '0;
            if_gnt     <= 1'b0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            htrans     <= TRANS_IDLE;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hsize      <= '0;
            hprot      <= '0;
            hwdata     <= '0;
            hmaster    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            wait_cnt   <= wait_n;
            wdata_lat  <= wdata_n;
            if_gnt     <= if_gnt_n;
            if_done    <= if_done_n;
            if_err     <= if_err_n;
            if_rdata   <= if_rdata_n;
            d_gnt      <= d_gnt_n;
            d_done     <= d_done_n;
            d_err      <= d_err_n;
            d_rdata    <= d_rdata_n;
            htrans     <= htrans_n;
            haddr      <= haddr_n;
            hwrite     <= hwrite_n;
            hsize      <= hsize_n;
            hprot      <= hprot_n;
            hwdata     <= hwdata_n;
            hmaster    <= hmaster_n;
        end
    end

    always_comb begin
        pick_if  = if_req && (!d_req || (starve_cnt >= STARVE_LIM));
        wait_inc = wait_cnt + 8'd1;
        case (d_size)
            3'd0:    d_aligned = 1'b1;
            3'd1:    d_aligned = !d_addr[0];
            3'd2:    d_aligned = (d_addr[1:0] == 2'b00);
            default: d_aligned = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        starve_n   = starve_cnt;
        wait_n     = wait_cnt;
        wdata_n    = wdata_lat;
        if_gnt_n   = 1'b0;
        if_done_n  = 1'b0;
        if_err_n   = 1'b0;
        if_rdata_n = if_rdata;
        d_gnt_n    = 1'b0;
        d_done_n   = 1'b0;
        d_err_n    = 1'b0;
        d_rdata_n  = d_rdata;
        htrans_n   = htrans;
        haddr_n    = haddr;
        hwrite_n   = hwrite;
        hsize_n    = hsize;
        hprot_n    = hprot;
        hwdata_n   = hwdata;
        hmaster_n  = hmaster;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;

        case (state)
            IDLE: begin
                htrans_n = TRANS_IDLE;
                if (pick_if) begin
                    if_gnt_n  = 1'b1;
                    haddr_n   = if_addr;
                    hwrite_n  = 1'b0;
                    hsize_n   = 3'b010;
                    hprot_n   = 4'b0010;
                    hmaster_n = 1'b0;
                    wait_n    = '0;
                    htrans_n  = TRANS_NONSEQ;
                    state_n   = ADDR;
                end else if (d_req) begin
                    d_gnt_n = 1'b1;
                    // Illegal size/alignment is answered locally; the bus never sees it.
                    if (d_aligned) begin
                        haddr_n   = d_addr;
                        hwrite_n  = d_write;
                        hsize_n   = d_size;
                        hprot_n   = 4'b0011;
                        wdata_n   = d_wdata;
                        hmaster_n = 1'b1;
                        wait_n    = '0;
                        htrans_n  = TRANS_NONSEQ;
                        state_n   = ADDR;
                    end else begin
                        state_n = REJ;
                    end
                end
            end
            ADDR: begin
                if (hready) begin
                    htrans_n = TRANS_IDLE;
                    hwdata_n = wdata_lat;
                    state_n  = DATA;
                end else if (wait_inc == TIMEOUT_LIM) begin
                    fin_err = 1'b1;
                end else begin
                    wait_n = wait_inc;
                end
            end
            DATA: begin
                if (hready) begin
                    fin_ok  = !hresp;
                    fin_err = hresp;
                end else if (wait_inc == TIMEOUT_LIM) begin
                    fin_err = 1'b1;
                end else begin
                    wait_n = wait_inc;
                    if (hresp) begin
                        state_n = ERR;
                    end
                end
            end
            ERR: begin
                if (hready || (wait_inc == TIMEOUT_LIM)) begin
                    fin_err = 1'b1;
                end else begin
                    wait_n = wait_inc;
                end
            end
            REJ: begin
                d_done_n = 1'b1;
                d_err_n  = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Completion is routed to whichever requester currently owns the bus.
        if (fin_ok || fin_err) begin
            state_n  = IDLE;
            htrans_n = TRANS_IDLE;
            if (hmaster) begin
                d_done_n  = 1'b1;
                d_err_n   = fin_err;
                d_rdata_n = fin_err ? 32'd0 : hrdata;
            end else begin
                if_done_n  = 1'b1;
                if_err_n   = fin_err;
                if_rdata_n = fin_err ? 32'd0 : hrdata;
            end
        end

        if (!if_req || if_gnt_n) begin
            starve_n = '0;
        end else if (d_gnt_n && (starve_cnt != 4'hF)) begin
            starve_n = starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios plus randomized
// single transfers checked against a transaction-level latency/result model.
module tb_ahb_bus_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_done, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_write;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_done, d_err;
    logic [31:0] d_rdata;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmaster;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hrdata;
    logic        hready, hresp;

    int checks   = 0;
    int failures = 0;

    ahb_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
        .d_rdata(d_rdata),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hprot(hprot), .hwdata(hwdata), .hmaster(hmaster),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_write = 1'b0;
        d_size  = 3'd2;
        d_addr  = '0;
        d_wdata = '0;
        hrdata  = '0;
        hready  = 1'b1;
        hresp   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({if_gnt, if_done, if_err, d_gnt, d_done, d_err, htrans, hwrite, hsize, hprot, hmaster} !== 18'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h, required 0", {if_gnt, if_done, if_err, d_gnt, d_done, d_err, htrans, hwrite, hsize, hprot, hmaster});
        end
        checks++;
        if ({haddr, hwdata, if_rdata, d_rdata} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data: got %h, required 0", {haddr, hwdata, if_rdata, d_rdata});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        hrdata  = 32'h0051_3023;
        tick();
        checks++;
        if ({if_gnt, d_gnt, htrans, haddr} !== {1'b1, 1'b0, 2'b10, 32'h40}) begin
            failures++;
            $display("FAIL fetch_gnt: got gnt=%b/%b htrans=%b haddr=%h, required 1/0 10 00000040", if_gnt, d_gnt, htrans, haddr);
        end
        checks++;
        if ({hprot, hsize, hwrite, hmaster} !== {4'b0010, 3'b010, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_attr: got hprot=%b hsize=%b hwrite=%b hmaster=%b", hprot, hsize, hwrite, hmaster);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({htrans, if_done} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_dphase: got htrans=%b if_done=%b, required 00 0", htrans, if_done);
        end
        tick();
        checks++;
        if ({if_done, if_err, d_done, if_rdata} !== {3'b100, 32'h0051_3023}) begin
            failures++;
            $display("FAIL fetch_done: got done=%b err=%b d_done=%b rdata=%h, required 1 0 0 00513023", if_done, if_err, d_done, if_rdata);
        end
        tick();
    endtask

    task automatic test_store_wait();
        d_req   = 1'b1;
        d_write = 1'b1;
        d_size  = 3'd2;
        d_addr  = 32'h1000_0008;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({d_gnt, htrans, haddr, hprot, hsize, hwrite, hmaster} !== {1'b1, 2'b10, 32'h1000_0008, 4'b0011, 3'b010, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL store_gnt: got gnt=%b htrans=%b haddr=%h hprot=%b hsize=%b hwrite=%b hmaster=%b", d_gnt, htrans, haddr, hprot, hsize, hwrite, hmaster);
        end
        d_req  = 1'b0;
        hready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({hwdata, htrans, d_done} !== {32'hDEAD_BEEF, 2'b00, 1'b0}) begin
                failures++;
                $display("FAIL store_wait%0d: got hwdata=%h htrans=%b done=%b, required deadbeef 00 0", i, hwdata, htrans, d_done);
            end
            hready = (i == 2);
            tick();
        end
        checks++;
        if ({d_done, d_err} !== 2'b10) begin
            failures++;
            $display("FAIL store_done: got done=%b err=%b, required 1 0", d_done, d_err);
        end
        d_write = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int model_cnt = 0;
        int grants    = 0;
        int cyc       = 0;
        bit exp_if;
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_write = 1'b0;
        d_size  = 3'd2;
        d_addr  = 32'h0000_0300;
        hready  = 1'b1;
        while (grants < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (if_gnt && d_gnt) begin
                checks++;
                failures++;
                $display("FAIL dual_gnt: both grants high in cycle %0d", cyc);
            end else if (if_gnt || d_gnt) begin
                exp_if = (model_cnt >= STARVE_LIMIT);
                checks++;
                if ({if_gnt, hmaster} !== {exp_if, !exp_if}) begin
                    failures++;
                    $display("FAIL grant%0d: got if_gnt=%b hmaster=%b, required %b %b", grants, if_gnt, hmaster, exp_if, !exp_if);
                end
                model_cnt = exp_if ? 0 : ((model_cnt < 15) ? model_cnt + 1 : 15);
                grants++;
            end
        end
        if (grants < 10) begin
            checks++;
            failures++;
            $display("FAIL contention_timeout: got %0d grants, required 10", grants);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_error();
        d_req   = 1'b1;
        d_write = 1'b0;
        d_size  = 3'd2;
        d_addr  = 32'h2000_0004;
        hrdata  = 32'h1234_5678;
        tick();
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL err_gnt: got %b, required 1", d_gnt);
        end
        d_req  = 1'b0;
        hready = 1'b1;
        tick();
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        checks++;
        if (d_done !== 1'b0) begin
            failures++;
            $display("FAIL err_early: got d_done=%b, required 0", d_done);
        end
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        checks++;
        if ({d_done, d_err, d_rdata} !== {2'b11, 32'd0}) begin
            failures++;
            $display("FAIL err_done: got done=%b err=%b rdata=%h, required 1 1 0", d_done, d_err, d_rdata);
        end
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        tick();
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL err_idle: got if_gnt=%b, required 1", if_gnt);
        end
        if_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({if_done, if_err, if_rdata} !== {2'b10, 32'h1234_5678}) begin
            failures++;
            $display("FAIL err_next: got done=%b err=%b rdata=%h, required 1 0 12345678", if_done, if_err, if_rdata);
        end
        tick();
    endtask

    task automatic test_timeout_misalign();
        int n = 0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        hready  = 1'b0;
        tick();
        if_req = 1'b0;
        while (!if_done && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if ({n, if_err, htrans} !== {TIMEOUT, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL timeout: got %0d cycles err=%b htrans=%b, required %0d 1 00", n, if_err, htrans, TIMEOUT);
        end
        hready = 1'b1;
        tick();
        checks++;
        if (if_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got if_done=%b, required 0", if_done);
        end
        d_req  = 1'b1;
        d_size = 3'd2;
        d_addr = 32'h1000_0002;
        tick();
        checks++;
        if ({d_gnt, htrans} !== 3'b100) begin
            failures++;
            $display("FAIL misalign_gnt: got gnt=%b htrans=%b, required 1 00", d_gnt, htrans);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({d_done, d_err, htrans} !== 4'b1100) begin
            failures++;
            $display("FAIL misalign_done: got done=%b err=%b htrans=%b, required 1 1 00", d_done, d_err, htrans);
        end
        tick();
        checks++;
        if ({d_done, htrans} !== 3'b000) begin
            failures++;
            $display("FAIL misalign_after: got done=%b htrans=%b, required 0 00", d_done, htrans);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit          is_d, wr, ok, early, bad_wdata;
            int          aw, dw, size;
            logic [31:0] addr, data, wdata;
            is_d  = 1'($urandom_range(0, 1));
            aw    = $urandom_range(0, 2);
            dw    = $urandom_range(0, 2);
            addr  = $urandom;
            data  = $urandom;
            wdata = $urandom;
            wr    = 1'b0;
            size  = 2;
            if (is_d) begin
                size = $urandom_range(0, 3);
                wr   = 1'($urandom_range(0, 1));
                ok   = (size <= 2) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
            end else begin
                addr[1:0] = 2'b00;
                ok = 1'b1;
            end
            hready  = 1'b1;
            hresp   = 1'b0;
            hrdata  = data;
            if_req  = !is_d;
            if_addr = addr;
            d_req   = is_d;
            d_addr  = addr;
            d_size  = 3'(size);
            d_write = wr;
            d_wdata = wdata;
            tick();
            if_req = 1'b0;
            d_req  = 1'b0;
            checks++;
            if ({if_gnt, d_gnt} !== {!is_d, is_d}) begin
                failures++;
                $display("FAIL rnd%0d_gnt: got if/d=%b%b, required %b%b", t, if_gnt, d_gnt, !is_d, is_d);
            end
            if (!ok) begin
                tick();
                checks++;
                if ({d_done, d_err, htrans} !== 4'b1100) begin
                    failures++;
                    $display("FAIL rnd%0d_rej: got done=%b err=%b htrans=%b, required 1 1 00", t, d_done, d_err, htrans);
                end
            end else begin
                checks++;
                if ({htrans, haddr, hwrite, hsize} !== {2'b10, addr, wr, 3'(size)}) begin
                    failures++;
                    $display("FAIL rnd%0d_addr: got htrans=%b haddr=%h hwrite=%b hsize=%0d, required 10 %h %b %0d", t, htrans, haddr, hwrite, hsize, addr, wr, size);
                end
                early     = 1'b0;
                bad_wdata = 1'b0;
                for (int j = 0; j < aw + dw + 2; j++) begin
                    hready = (j == aw) || (j == aw + dw + 1);
                    tick();
                    if (j < aw + dw + 1 && (if_done || d_done)) early = 1'b1;
                    if (j == aw && wr && hwdata !== wdata) bad_wdata = 1'b1;
                end
                checks++;
                if ({early, bad_wdata} !== 2'b00) begin
                    failures++;
                    $display("FAIL rnd%0d_phase: got early_done=%b bad_hwdata=%b, required 0 0", t, early, bad_wdata);
                end
                checks++;
                if (is_d ? ({d_done, d_err, if_done, d_rdata} !== {3'b100, data})
                         : ({if_done, if_err, d_done, if_rdata} !== {3'b100, data})) begin
                    failures++;
                    $display("FAIL rnd%0d_done: got if=%b/%b/%h d=%b/%b/%h, required owner %0d done rdata %h", t, if_done, if_err, if_rdata, d_done, d_err, d_rdata, is_d, data);
                end
            end
        end
        hready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        d_req   = 1'b1;
        d_write = 1'b0;
        d_size  = 3'd2;
        d_addr  = 32'h0000_0400;
        tick();
        d_req  = 1'b0;
        hready = 1'b1;
        tick();
        hready = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({htrans, d_gnt, d_done, d_err, hmaster, hwrite, haddr} !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid: got htrans=%b gnt=%b done=%b err=%b hmaster=%b haddr=%h, required all 0", htrans, d_gnt, d_done, d_err, hmaster, haddr);
        end
        hready = 1'b1;
        repeat (2) begin
            tick();
            if (d_done || if_done) seen = 1'b1;
        end
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h0000_0044;
        hrdata  = 32'hCAFE_F00D;
        tick();
        if (d_done) seen = 1'b1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL reset_regrant: got if_gnt=%b, required 1", if_gnt);
        end
        if_req = 1'b0;
        tick();
        if (d_done) seen = 1'b1;
        tick();
        checks++;
        if ({if_done, if_err, if_rdata, seen} !== {2'b10, 32'hCAFE_F00D, 1'b0}) begin
            failures++;
            $display("FAIL reset_recover: got done=%b err=%b rdata=%h stray_done=%b, required 1 0 cafef00d 0", if_done, if_err, if_rdata, seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_contention();
        test_error();
        test_timeout_misalign();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
